// File: rtl/onchip_mem_arbiter_2m.sv
// onchip_mem_arbiter_2m
//   Two-master Avalon-MM arbiter in front of a single-port on-chip RAM with a
//   1-cycle read latency. The current owner keeps the port for as long as it
//   requests, or for up to MAX_BURST consecutive grants when the other master
//   is also waiting. Grants are combinational and are reported back as
//   waitrequest. Read data is returned with readdatavalid one cycle after the
//   read is accepted.
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   mN_address/byteenable/read/write/writedata   master N request (N = 0,1)
//   mN_waitrequest         1 = request not accepted this cycle
//   mN_readdata/readdatavalid                    read return, 1 cycle after accept
//   mem_address/byteenable/chipselect/write/writedata/clken   RAM slave port
//   mem_readdata           RAM q (unregistered in the RAM wrapper)
module onchip_mem_arbiter_2m #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BE_W      = 4,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rd_valid_q, rd_valid_d;

  logic req0, req1;
  logic gnt0, gnt1;
  logic burst_open;

  assign req0       = m0_read | m0_write;
  assign req1       = m1_read | m1_write;
  assign burst_open = (cnt_q < MAX_CNT);

  // Grant, next owner and burst count. Nothing is granted while reset is high,
  // so the registered state is ignored until it has been cleared.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = IDLE;
    last_d  = last_q;
    cnt_d   = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (req0 && req1) begin
            if (last_q) gnt0 = 1'b1;
            else        gnt1 = 1'b1;
          end else if (req0) begin
            gnt0 = 1'b1;
          end else if (req1) begin
            gnt1 = 1'b1;
          end
        end
        OWN0: begin
          if (req0 && (burst_open || !req1)) gnt0 = 1'b1;
          else if (req1)                     gnt1 = 1'b1;
        end
        OWN1: begin
          if (req1 && (burst_open || !req0)) gnt1 = 1'b1;
          else if (req0)                     gnt0 = 1'b1;
        end
        default: ;
      endcase

      // Counter restarts at 1 whenever ownership moves (including from IDLE)
      // and saturates at MAX_BURST while the same owner keeps the port.
      if (gnt0) begin
        state_d = OWN0;
        last_d  = 1'b0;
        if (state_q == OWN0) cnt_d = burst_open ? cnt_q + CNT_W'(1) : cnt_q;
        else                 cnt_d = CNT_W'(1);
      end else if (gnt1) begin
        state_d = OWN1;
        last_d  = 1'b1;
        if (state_q == OWN1) cnt_d = burst_open ? cnt_q + CNT_W'(1) : cnt_q;
        else                 cnt_d = CNT_W'(1);
      end
    end
  end

  // A simultaneous read and write is treated as a write: no data is returned.
  assign rd_valid_d = {gnt1 & m1_read & ~m1_write, gnt0 & m0_read & ~m0_write};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // RAM port mux
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (gnt0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_write ? m0_byteenable : '1;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_writedata  = m0_writedata;
    end else if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_write ? m1_byteenable : '1;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_writedata  = m1_writedata;
    end
  end

  assign mem_clken      = 1'b1;
  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  // Masking with reset drops a read that was accepted just before reset rose.
  assign m0_readdatavalid = rd_valid_q[0] & ~reset;
  assign m1_readdatavalid = rd_valid_q[1] & ~reset;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule
